// File: rtl/riscv_regfile_mp.sv
// Multi-read-port integer register file with a write-back delay line and per-port pending-write flags.
// Optional forwarding from the in-flight writes is enabled by defining REGFILE_BYPASS_EN.
module riscv_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int WB_DELAY = 1,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              RegWEn_i,
  input  logic [AW-1:0]     AddrD_i,
  input  logic [XLEN-1:0]   DataD_i,
  input  logic              Flush_i,
  input  logic [NRD*AW-1:0] AddrR_i,
  output logic [NRD*XLEN-1:0] DataR_o,
  output logic [NRD-1:0]    Pend_o
);

  localparam int SD = (WB_DELAY > 0) ? WB_DELAY : 1;

  logic [XLEN-1:0] regArray [NREG];

  logic            stgValid [SD];
  logic [AW-1:0]   stgAddr  [SD];
  logic [XLEN-1:0] stgData  [SD];

  logic            writeValid;
  logic            commitValid;
  logic [AW-1:0]   commitAddr;
  logic [XLEN-1:0] commitData;

  logic [AW-1:0]   rdAddr;
  logic [XLEN-1:0] rdData;
  logic            rdPend;

  function automatic logic inRange(input logic [AW-1:0] a);
    return 32'(a) < 32'(NREG);
  endfunction

  // x0 and unimplemented registers never enter the delay line
  assign writeValid = RegWEn_i && (AddrD_i != '0) && inRange(AddrD_i);

  if (WB_DELAY == 0) begin : gNoDelay
    always_comb begin
      for (int s = 0; s < SD; s++) begin
        stgValid[s] = 1'b0;
        stgAddr[s]  = '0;
        stgData[s]  = '0;
      end
    end

    assign commitValid = writeValid && !Flush_i;
    assign commitAddr  = AddrD_i;
    assign commitData  = DataD_i;
  end else begin : gDelay
    // Flush kills every stage, including the one that would commit at this edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s < WB_DELAY; s++) begin
          stgValid[s] <= 1'b0;
          stgAddr[s]  <= '0;
          stgData[s]  <= '0;
        end
      end else if (Flush_i) begin
        for (int s = 0; s < WB_DELAY; s++) begin
          stgValid[s] <= 1'b0;
        end
      end else begin
        stgValid[0] <= writeValid;
        stgAddr[0]  <= AddrD_i;
        stgData[0]  <= DataD_i;
        for (int s = 1; s < WB_DELAY; s++) begin
          stgValid[s] <= stgValid[s-1];
          stgAddr[s]  <= stgAddr[s-1];
          stgData[s]  <= stgData[s-1];
        end
      end
    end

    assign commitValid = stgValid[WB_DELAY-1] && !Flush_i;
    assign commitAddr  = stgAddr[WB_DELAY-1];
    assign commitData  = stgData[WB_DELAY-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREG; r++) begin
        regArray[r] <= '0;
      end
    end else if (commitValid) begin
      regArray[commitAddr] <= commitData;
    end
  end

  // Forwarding overrides oldest-to-youngest so the most recent write wins
  always_comb begin
    DataR_o = '0;
    Pend_o  = '0;
    rdAddr  = '0;
    rdData  = '0;
    rdPend  = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      rdAddr = AddrR_i[p*AW +: AW];
      rdData = '0;
      rdPend = 1'b0;
      if ((rdAddr != '0) && inRange(rdAddr)) begin
        rdData = regArray[rdAddr];
        for (int s = 0; s < WB_DELAY; s++) begin
          if (stgValid[s] && (stgAddr[s] == rdAddr)) begin
            rdPend = 1'b1;
          end
        end
`ifdef REGFILE_BYPASS_EN
        for (int s = WB_DELAY - 1; s >= 0; s--) begin
          if (stgValid[s] && (stgAddr[s] == rdAddr)) begin
            rdData = stgData[s];
          end
        end
        if (writeValid && !Flush_i && (AddrD_i == rdAddr)) begin
          rdData = DataD_i;
        end
`endif
      end
      if (rst_ni) begin
        DataR_o[p*XLEN +: XLEN] = rdData;
        Pend_o[p]               = rdPend;
      end
    end
  end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Scoreboard bench for riscv_regfile_mp (XLEN=32, NREG=32, NRD=2, WB_DELAY=2) against a write-list model.
module tb_riscv_regfile_mp;

  localparam int WBD = 2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        regWEn;
  logic [4:0]  addrD;
  logic [31:0] dataD;
  logic        flush;
  logic [9:0]  addrR;
  logic [63:0] dataR;
  logic [1:0]  pend;

  riscv_regfile_mp #(
    .XLEN(32), .NREG(32), .NRD(2), .WB_DELAY(WBD)
  ) dut (
    .clk_i(clk), .rst_ni(rstN), .RegWEn_i(regWEn), .AddrD_i(addrD), .DataD_i(dataD),
    .Flush_i(flush), .AddrR_i(addrR), .DataR_o(dataR), .Pend_o(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  pend;
    string       tag;
  } exp_t;

  logic [31:0] mArr [32];
  wr_t         inflight [$];
  exp_t        expQ [$];
  int          edgeNum = 0;
  bit          inReset = 1'b1;
  int          checks = 0;
  int          errors = 0;

  logic        curWe, curFlush;
  logic [4:0]  curAddrD, curA0, curA1;
  logic [31:0] curDataD;

  // Register state advances one edge: flush drops everything, otherwise due writes retire in issue order
  task automatic modelEdge();
    edgeNum++;
    if (curFlush) begin
      inflight.delete();
    end else begin
      while (inflight.size() > 0 && inflight[0].due <= edgeNum) begin
        mArr[inflight[0].addr] = inflight[0].data;
        void'(inflight.pop_front());
      end
      if (curWe && curAddrD != 5'd0) begin
        if (WBD == 0) mArr[curAddrD] = curDataD;
        else inflight.push_back('{due: edgeNum + WBD, addr: curAddrD, data: curDataD});
      end
    end
  endtask

  task automatic modelRead(input logic [4:0] a, output logic [31:0] d, output logic p);
    d = (a == 5'd0) ? 32'd0 : mArr[a];
    p = 1'b0;
    foreach (inflight[i]) begin
      if (a != 5'd0 && inflight[i].addr == a) begin
        p = 1'b1;
`ifdef REGFILE_BYPASS_EN
        d = inflight[i].data;
`endif
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (curWe && !curFlush && curAddrD != 5'd0 && curAddrD == a) d = curDataD;
`endif
  endtask

  task automatic pushExpect(input string tag);
    exp_t e;
    logic [31:0] d0, d1;
    logic p0, p1;
    modelRead(curA0, d0, p0);
    modelRead(curA1, d1, p1);
    e.data = inReset ? 64'd0 : {d1, d0};
    e.pend = inReset ? 2'b00 : {p1, p0};
    e.tag  = tag;
    expQ.push_back(e);
  endtask

  task automatic driveInputs();
    regWEn = curWe;
    addrD  = curAddrD;
    dataD  = curDataD;
    flush  = curFlush;
    addrR  = {curA1, curA0};
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] ad, input logic [31:0] dd,
                               input logic fl, input logic [4:0] a0, input logic [4:0] a1,
                               input string tag);
    @(posedge clk);
    if (!inReset) modelEdge();
    #1;
    curWe = we; curAddrD = ad; curDataD = dd; curFlush = fl; curA0 = a0; curA1 = a1;
    driveInputs();
    pushExpect(tag);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actD, input logic [63:0] expD,
                             input logic [1:0] actP, input logic [1:0] expP);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (actD[p*32 +: 32] !== expD[p*32 +: 32]) begin
        errors++;
        $display("[TB] FAIL %s port%0d data: got %h expected %h", tag, p, actD[p*32 +: 32], expD[p*32 +: 32]);
      end
      checks++;
      if (actP[p] !== expP[p]) begin
        errors++;
        $display("[TB] FAIL %s port%0d pend: got %b expected %b", tag, p, actP[p], expP[p]);
      end
    end
  endtask

  task automatic clearModel();
    foreach (mArr[i]) mArr[i] = 32'd0;
    inflight.delete();
  endtask

  // Reset lands between edges so the array must clear without waiting for a clock
  task automatic assertReset(input logic [4:0] a0, input logic [4:0] a1);
    @(posedge clk);
    if (!inReset) modelEdge();
    #1;
    curWe = 1'b0; curAddrD = 5'd0; curDataD = 32'd0; curFlush = 1'b0; curA0 = a0; curA1 = a1;
    driveInputs();
    rstN = 1'b0;
    inReset = 1'b1;
    clearModel();
    #1;
    checkOutput("async_reset", dataR, 64'd0, pend, 2'b00);
    pushExpect("in_reset");
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    curWe = 1'b0; curAddrD = 5'd0; curDataD = 32'd0; curFlush = 1'b0; curA0 = 5'd0; curA1 = 5'd1;
    driveInputs();
    rstN = 1'b1;
    inReset = 1'b0;
    pushExpect("release");
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput(e.tag, dataR, e.data, pend, e.pend);
      end
    end
  end

  initial begin
    clearModel();
    rstN = 1'b0;
    curWe = 1'b1; curAddrD = 5'd2; curDataD = 32'h55; curFlush = 1'b0; curA0 = 5'd2; curA1 = 5'd1;
    driveInputs();
    #2;
    checkOutput("reset_state", dataR, 64'd0, pend, 2'b00);
    applyStimulus(1'b1, 5'd2, 32'h55, 1'b0, 5'd2, 5'd1, "during_reset");
    releaseReset();

    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, "t1_idle");
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd1, "t1_x0_write");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, "t1_x0_read");

    applyStimulus(1'b1, 5'd2, 32'h16, 1'b0, 5'd2, 5'd0, "t2_e0");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 5'd0, "t2_after");

    applyStimulus(1'b1, 5'd5, 32'h18, 1'b0, 5'd5, 5'd5, "t4_w1");
    applyStimulus(1'b1, 5'd5, 32'h20, 1'b0, 5'd5, 5'd5, "t4_w2");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5, "t4_after");

    applyStimulus(1'b1, 5'd8, 32'h77, 1'b0, 5'd8, 5'd9, "t5_write");
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 5'd9, "t5_flush");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 5'd9, "t5_after");

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                    1'($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), "random");
    end

    applyStimulus(1'b1, 5'd3, 32'h15, 1'b0, 5'd3, 5'd4, "t6_write");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd4, "t6_commit");
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd3, 5'd4, "t6_inflight");
    assertReset(5'd3, 5'd4);
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 5'd4, "t6_held");
    releaseReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd4, "t6_after");

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations required 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
